// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed at launch into shadow registers and committed to HI/LO after the configured latency.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] shadow_hi;
    logic [WIDTH-1:0] shadow_lo;

    logic             launch;
    logic             commit;
    logic             write_en;

    logic             is_signed;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] product;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && !cancel) state_next = RUN;
            RUN:  if (cancel || count == CNT_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        busy     = (state == RUN);
        launch   = (state == IDLE) && start && !cancel;
        commit   = (state == RUN) && !cancel && (count == CNT_W'(1));
        // A start in the same idle cycle takes priority over direct HI/LO writes.
        write_en = (state == IDLE) && !start;
    end

    // ---------------- result datapath ----------------
    // Sign-extending both operands to 2*WIDTH lets one unsigned multiplier serve mult and multu.
    always_comb begin
        is_signed = ~op[0];
        a_ext     = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
        b_ext     = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
        product   = a_ext * b_ext;

        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        q_mag     = a_mag / b_mag;
        r_mag     = a_mag % b_mag;
        // Most-negative / -1 falls out naturally: the magnitude quotient negates back to itself.
        quotient  = (a_neg ^ b_neg) ? -q_mag : q_mag;
        remainder = a_neg ? -r_mag : r_mag;

        res_hi = product[2*WIDTH-1:WIDTH];
        res_lo = product[WIDTH-1:0];
        if (op[1]) begin
            if (b == '0) begin
                res_hi = a;
                res_lo = '1;
            end else begin
                res_hi = remainder;
                res_lo = quotient;
            end
        end
    end

    // ---------------- latency counter ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (launch) begin
            count <= op[1] ? DIV_LOAD : MULT_LOAD;
        end else if (busy) begin
            count <= cancel ? '0 : count - CNT_W'(1);
        end
    end

    // ---------------- shadow result ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_hi <= '0;
            shadow_lo <= '0;
        end else if (launch) begin
            shadow_hi <= res_hi;
            shadow_lo <= res_lo;
        end
    end

    // ---------------- architectural HI/LO and done ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= commit;
            if (commit) begin
                hi <= shadow_hi;
                lo <= shadow_lo;
            end else if (write_en) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized cycles,
// compared each cycle against a transaction-level reference built on 64-bit arithmetic.
module tb_md_unit;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state: remaining busy cycles, pending result, architectural regs.
    int         m_left = 0;
    logic [W-1:0] m_phi = '0, m_plo = '0, m_hi = '0, m_lo = '0;
    logic       m_done = 1'b0;

    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint q;
        longint r;
        logic [63:0] ux = {32'b0, x};
        logic [63:0] uy = {32'b0, y};
        case (o)
            2'b00: return 64'(sx * sy);
            2'b01: return ux * uy;
            2'b10: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {32'(ux % uy), 32'(ux / uy)};
            end
        endcase
    endfunction

    // One clock cycle: drive inputs, advance the model, then compare after the edge.
    task automatic cycle(input logic st, input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic cn, input logic hw, input logic lw, input logic [W-1:0] wd);
        start = st; op = o; a = xa; b = xb; cancel = cn; hi_we = hw; lo_we = lw; wdata = wd;
        m_done = 1'b0;
        if (m_left > 0) begin
            if (cn) begin
                m_left = 0;
            end else if (m_left == 1) begin
                m_hi = m_phi; m_lo = m_plo; m_done = 1'b1; m_left = 0;
            end else begin
                m_left = m_left - 1;
            end
        end else if (st && !cn) begin
            m_left = o[1] ? DC : MC;
            {m_phi, m_plo} = ref_result(o, xa, xb);
        end else if (!st) begin
            if (hw) m_hi = wd;
            if (lw) m_lo = wd;
        end
        @(posedge clk);
        #1;
        check("busy", 64'(busy), 64'(m_left > 0));
        check("done", 64'(done), 64'(m_done));
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 2'b00, '0, '0, 0, 0, 0, '0);
    endtask

    task automatic launch(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
        cycle(1, o, xa, xb, 0, 0, 0, '0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] specials [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
        int sel = $urandom_range(0, 9);
        if (sel < 3) return specials[$urandom_range(0, 3)];
        if (sel < 5) return W'($urandom_range(0, 20));
        return $urandom;
    endfunction

    initial begin
        reset = 1'b1; start = 0; op = 0; a = 0; b = 0; cancel = 0; hi_we = 0; lo_we = 0; wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        reset = 1'b0;

        // mult -3 * 5
        launch(2'b00, 32'hFFFF_FFFD, 32'd5);
        idle(MC);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFF1);
        check("mult_done", 64'(done), 64'(1));
        idle(1);
        check("mult_done_once", 64'(done), 64'(0));

        // multu 0xFFFFFFFF * 2
        launch(2'b01, 32'hFFFF_FFFF, 32'd2);
        idle(MC);
        check("multu_hi", 64'(hi), 64'h1);
        check("multu_lo", 64'(lo), 64'hFFFF_FFFE);

        // div -7 / 2
        launch(2'b10, 32'hFFFF_FFF9, 32'd2);
        idle(DC - 1);
        check("div_busy_last", 64'(busy), 64'(1));
        idle(1);
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi), 64'hFFFF_FFFF);

        // divu by zero
        launch(2'b11, 32'h1234, 32'h0);
        idle(DC);
        check("divz_lo", 64'(lo), 64'hFFFF_FFFF);
        check("divz_hi", 64'(hi), 64'h1234);

        // signed overflow
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DC);
        check("ovf_lo", 64'(lo), 64'h8000_0000);
        check("ovf_hi", 64'(hi), 64'h0);

        // start and hi_we during a divide are ignored
        launch(2'b10, 32'd100, 32'd7);
        for (int k = 1; k <= DC; k++) begin
            if (k == 4)      cycle(1, 2'b00, 32'd2, 32'd3, 0, 0, 0, '0);
            else if (k == 6) cycle(0, 2'b00, '0, '0, 0, 1, 0, 32'hAA);
            else             idle(1);
        end
        check("busy_div_lo", 64'(lo), 64'd14);
        check("busy_div_hi", 64'(hi), 64'd2);
        idle(1);
        check("busy_no_relaunch", 64'(busy), 64'(0));

        // idle direct write, then start + lo_we in the same cycle
        cycle(0, 2'b00, '0, '0, 0, 1, 0, 32'h55);
        check("mthi", 64'(hi), 64'h55);
        cycle(1, 2'b00, 32'd7, 32'd9, 0, 0, 1, 32'hDEAD);
        idle(MC);
        check("start_wins_lo", 64'(lo), 64'h3F);

        // cancel mid-operation
        cycle(0, 2'b00, '0, '0, 0, 1, 0, 32'h11);
        cycle(0, 2'b00, '0, '0, 0, 0, 1, 32'h22);
        launch(2'b00, 32'd4, 32'd4);
        idle(2);
        cycle(0, 2'b00, '0, '0, 1, 0, 0, '0);
        check("cancel_busy", 64'(busy), 64'(0));
        check("cancel_hi", 64'(hi), 64'h11);
        check("cancel_lo", 64'(lo), 64'h22);
        idle(MC);

        // cancel on the commit cycle suppresses the commit
        launch(2'b01, 32'd6, 32'd6);
        idle(MC - 1);
        cycle(0, 2'b00, '0, '0, 1, 0, 0, '0);
        check("cancel_commit_lo", 64'(lo), 64'h22);
        check("cancel_commit_done", 64'(done), 64'(0));

        // start together with cancel while idle launches nothing
        cycle(1, 2'b00, 32'd3, 32'd3, 1, 0, 0, '0);
        check("start_cancel_idle", 64'(busy), 64'(0));

        // asynchronous reset mid-operation
        launch(2'b00, 32'd5, 32'd5);
        idle(1);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_hi", 64'(hi), 64'(0));
        check("arst_lo", 64'(lo), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        m_left = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_done = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        // randomized cycles
        for (int i = 0; i < 3000; i++) begin
            logic st  = ($urandom_range(0, 99) < 30);
            logic cn  = ($urandom_range(0, 99) < 5);
            logic hw  = ($urandom_range(0, 99) < 20);
            logic lw  = ($urandom_range(0, 99) < 20);
            logic [1:0] o = 2'($urandom_range(0, 3));
            logic [W-1:0] xa = pick_operand();
            logic [W-1:0] xb = pick_operand();
            logic [W-1:0] wd = $urandom;
            cycle(st, o, xa, xb, cn, hw, lw, wd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit for the pipelined MIPS core, sitting beside the ALU in the E stage. It holds the architectural HI/LO registers and runs mult/multu/div/divu as multi-cycle operations with a configurable latency. It exports a busy flag so the stall controller can freeze D-stage instructions that touch HI/LO. It also supports direct HI/LO writes (mthi/mtlo) and abort of an in-flight operation on pipeline flush.

## Interface
- WIDTH, 32: operand and HI/LO width in bits.
- MULT_CYCLES, 5: multiply latency in cycles; legal range is 1 or more.
- DIV_CYCLES, 10: divide latency in cycles; legal range is 1 or more.

- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  launch an operation this cycle; honoured only when idle.
- op  in  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
- a  in  WIDTH  rs operand (multiplicand or dividend).
- b  in  WIDTH  rt operand (multiplier or divisor).
- cancel  in  1  abort the in-flight operation (E-stage flush).
- hi_we  in  1  write wdata to HI (mthi).
- lo_we  in  1  write wdata to LO (mtlo).
- wdata  in  WIDTH  data for hi_we/lo_we.
- busy  out  1  an operation is in flight.
- done  out  1  one-cycle pulse after HI/LO commit.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE and RUN. A down-counter (width sized for max(MULT_CYCLES, DIV_CYCLES)) tracks remaining cycles.
- IDLE -> RUN on start:
  - Latch op, a and b.
  - Load the counter with MULT_CYCLES for op[1]=0, or DIV_CYCLES for op[1]=1.
  - The result goes into shadow registers; HI/LO are not yet changed.
- RUN:
  - The counter decrements each cycle.
  - When it reaches 1, the next edge commits the shadow to HI/LO, returns to IDLE, and sets done for one cycle.
- Multiply: the 2*WIDTH product is written with HI = upper half and LO = lower half. mult is two's-complement; multu is unsigned.
- Divide: LO = quotient, HI = remainder.
  - div truncates toward zero; the remainder takes the sign of the dividend.
  - divu is unsigned.
- Divide by zero (div or divu): LO = all ones, HI = dividend.
- Signed overflow (div of most-negative value by -1): LO = most-negative value, HI = 0.
- start while busy: ignored. Operands are not re-latched and the counter is unaffected.
- hi_we/lo_we while busy: ignored.
- hi_we/lo_we while idle with no start: the selected register(s) take wdata at the edge. If both are set, both take wdata.
- start and hi_we/lo_we in the same idle cycle: start wins and the write is discarded.
- cancel while busy:
  - The next edge returns to IDLE with HI/LO unchanged and done not pulsed.
  - cancel on the commit cycle also suppresses the commit.
- cancel while idle: no effect. If start and cancel are in the same cycle, cancel wins and nothing launches.
- The stall controller stalls mult*/div*/mfhi/mflo/mthi/mtlo in D while (start | busy). This unit does not generate that stall.

## Timing
- Reset value of every output: busy = 0, done = 0, hi = 0, lo = 0. Internal state is IDLE, counter 0, shadows 0.
- Reset asserted mid-operation: immediate return to IDLE; the result is discarded.
- busy rises at the edge that samples start (T0). It stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES) and falls at edge T0+N.
- HI/LO change at edge T0+N. done is high for the cycle following T0+N.
- A new start is accepted in the same cycle busy is low, i.e. the cycle after T0+N. This gives back-to-back throughput of one operation per N+1 cycles.
- hi_we/lo_we latency: one edge. hi/lo are register outputs with no combinational path from any input.

## Test plan
- mult a=0xFFFFFFFD (-3), b=5 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, with done pulsing once.
- multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE. div a=-7, b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234. div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- During div, pulse start (mult 2*3) at cycle 4 and hi_we (wdata=0xAA) at cycle 6 -> both ignored; only the div result commits at cycle 10.
- Idle: hi_we=1, wdata=0x55 -> hi=0x55 next edge. Then start+lo_we in the same cycle -> lo holds the multiply result, not wdata.
- mult running with hi=0x11, lo=0x22 preloaded: cancel at cycle 3 -> busy low next edge, hi/lo stay 0x11/0x22, no done. In a separate run, reset at cycle 2 -> all outputs 0 immediately.
